// File: rtl/client_wr_buffer.sv
// Per-client request buffer: posts writes into a DEPTH-entry FIFO, then drains them to the arbiter.
// Reads wait behind every buffered write. Define READ_FORWARD_EN to answer reads that hit a buffered write directly.
module client_wr_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_WIDTH-1:0]        client_address,
    input  logic                         client_rq,
    output logic                         client_ack,
    input  logic                         client_wr_ni,
    input  logic [DATA_WIDTH-1:0]        client_dataW,
    output logic [DATA_WIDTH-1:0]        client_dataR,
    output logic [ADDR_WIDTH-1:0]        bus_address,
    output logic                         bus_rq,
    input  logic                         bus_ack,
    output logic                         bus_wr_ni,
    output logic [DATA_WIDTH-1:0]        bus_dataW,
    input  logic [DATA_WIDTH-1:0]        bus_dataR,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_ACK  = 2'd1,
        C_RD   = 2'd2
    } c_state_t;

    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_WR   = 2'd1,
        B_RD   = 2'd2
    } b_state_t;

    c_state_t                r_c_state;
    c_state_t                w_c_next;
    b_state_t                r_b_state;
    b_state_t                w_b_next;

    logic                    r_client_ack;
    logic [DATA_WIDTH-1:0]   r_client_dataR;
    logic                    r_bus_rq;
    logic                    r_bus_wr_ni;
    logic [ADDR_WIDTH-1:0]   r_bus_address;
    logic [DATA_WIDTH-1:0]   r_bus_dataW;

    logic [CW-1:0]           r_count;
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [ADDR_WIDTH-1:0]   r_mem_addr [DEPTH];
    logic [DATA_WIDTH-1:0]   r_mem_data [DEPTH];

    logic                    r_rd_pend;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_rd_start;
    logic                    w_rd_done;
    logic                    w_fwd_hit;
    logic [DATA_WIDTH-1:0]   w_fwd_data;
    logic [DATA_WIDTH-1:0]   w_dataR_nxt;
    logic                    w_bus_rq_nxt;
    logic                    w_bus_wr_ni_nxt;
    logic [ADDR_WIDTH-1:0]   w_bus_address_nxt;
    logic [DATA_WIDTH-1:0]   w_bus_dataW_nxt;

    assign client_ack   = r_client_ack;
    assign client_dataR = r_client_dataR;
    assign bus_rq       = r_bus_rq;
    assign bus_wr_ni    = r_bus_wr_ni;
    assign bus_address  = r_bus_address;
    assign bus_dataW    = r_bus_dataW;
    assign fifo_count   = r_count;

    // Full uses the registered count, so a pop in the same cycle never frees a slot early.
    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == {CW{1'b0}});
    assign w_rd_done = (r_b_state == B_RD) && bus_ack;

`ifdef READ_FORWARD_EN
    logic [PW-1:0] w_fwd_idx;

    // Scan valid entries oldest to youngest so the youngest match wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = {DATA_WIDTH{1'b0}};
        w_fwd_idx  = r_rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            w_fwd_idx = r_rd_ptr + PW'(k);
            if ((CW'(k) < r_count) && (r_mem_addr[w_fwd_idx] == client_address)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_mem_data[w_fwd_idx];
            end else begin
                w_fwd_hit  = w_fwd_hit;
            end
        end
    end
`else
    assign w_fwd_hit  = 1'b0;
    assign w_fwd_data = {DATA_WIDTH{1'b0}};
`endif

    // Client FSM next state; rq is ignored while the previous ack is still on the wire.
    always_comb begin
        w_c_next    = r_c_state;
        w_push      = 1'b0;
        w_rd_start  = 1'b0;
        w_dataR_nxt = r_client_dataR;
        case (r_c_state)
            C_IDLE: begin
                if (client_rq && !r_client_ack) begin
                    if (client_wr_ni) begin
                        if (!w_full) begin
                            w_push   = 1'b1;
                            w_c_next = C_ACK;
                        end else begin
                            w_c_next = C_IDLE;
                        end
                    end else if (w_fwd_hit) begin
                        w_dataR_nxt = w_fwd_data;
                        w_c_next    = C_ACK;
                    end else begin
                        w_rd_start = 1'b1;
                        w_c_next   = C_RD;
                    end
                end else begin
                    w_c_next = C_IDLE;
                end
            end
            C_ACK: begin
                w_c_next = C_IDLE;
            end
            C_RD: begin
                if (w_rd_done) begin
                    w_dataR_nxt = bus_dataR;
                    w_c_next    = C_ACK;
                end else begin
                    w_c_next = C_RD;
                end
            end
            default: begin
                w_c_next = C_IDLE;
            end
        endcase
    end

    // Bus FSM next state; buffered writes always go ahead of a pending read.
    always_comb begin
        w_b_next          = r_b_state;
        w_pop             = 1'b0;
        w_bus_rq_nxt      = r_bus_rq;
        w_bus_wr_ni_nxt   = r_bus_wr_ni;
        w_bus_address_nxt = r_bus_address;
        w_bus_dataW_nxt   = r_bus_dataW;
        case (r_b_state)
            B_IDLE: begin
                if (!w_empty) begin
                    w_bus_rq_nxt      = 1'b1;
                    w_bus_wr_ni_nxt   = 1'b1;
                    w_bus_address_nxt = r_mem_addr[r_rd_ptr];
                    w_bus_dataW_nxt   = r_mem_data[r_rd_ptr];
                    w_b_next          = B_WR;
                end else if (r_rd_pend) begin
                    w_bus_rq_nxt      = 1'b1;
                    w_bus_wr_ni_nxt   = 1'b0;
                    w_bus_address_nxt = r_rd_addr;
                    w_b_next          = B_RD;
                end else begin
                    w_b_next = B_IDLE;
                end
            end
            B_WR: begin
                if (bus_ack) begin
                    w_pop        = 1'b1;
                    w_bus_rq_nxt = 1'b0;
                    w_b_next     = B_IDLE;
                end else begin
                    w_b_next = B_WR;
                end
            end
            B_RD: begin
                if (bus_ack) begin
                    w_bus_rq_nxt = 1'b0;
                    w_b_next     = B_IDLE;
                end else begin
                    w_b_next = B_RD;
                end
            end
            default: begin
                w_bus_rq_nxt = 1'b0;
                w_b_next     = B_IDLE;
            end
        endcase
    end

    // FSM state, read-pending flag and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c_state      <= C_IDLE;
            r_b_state      <= B_IDLE;
            r_client_ack   <= 1'b0;
            r_client_dataR <= {DATA_WIDTH{1'b0}};
            r_bus_rq       <= 1'b0;
            r_bus_wr_ni    <= 1'b0;
            r_bus_address  <= {ADDR_WIDTH{1'b0}};
            r_bus_dataW    <= {DATA_WIDTH{1'b0}};
            r_rd_pend      <= 1'b0;
            r_rd_addr      <= {ADDR_WIDTH{1'b0}};
        end else begin
            r_c_state      <= w_c_next;
            r_b_state      <= w_b_next;
            r_client_ack   <= (r_c_state == C_ACK);
            r_client_dataR <= w_dataR_nxt;
            r_bus_rq       <= w_bus_rq_nxt;
            r_bus_wr_ni    <= w_bus_wr_ni_nxt;
            r_bus_address  <= w_bus_address_nxt;
            r_bus_dataW    <= w_bus_dataW_nxt;
            if (w_rd_start) begin
                r_rd_pend <= 1'b1;
                r_rd_addr <= client_address;
            end else if (w_rd_done) begin
                r_rd_pend <= 1'b0;
            end
        end
    end

    // Write FIFO storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= {CW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_addr[i] <= {ADDR_WIDTH{1'b0}};
                r_mem_data[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_mem_addr[r_wr_ptr] <= client_address;
                r_mem_data[r_wr_ptr] <= client_dataW;
                r_wr_ptr             <= r_wr_ptr + PW'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1'b1);
                2'b01:   r_count <= r_count - CW'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_client_wr_buffer.sv
// Scoreboard bench for client_wr_buffer: client transactions queue the bus traffic they imply,
// and a server model pops and compares each bus request when it acknowledges it.
module tb_client_wr_buffer;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } btxn_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] client_address;
    logic          client_rq;
    logic          client_ack;
    logic          client_wr_ni;
    logic [DW-1:0] client_dataW;
    logic [DW-1:0] client_dataR;
    logic [AW-1:0] bus_address;
    logic          bus_rq;
    logic          bus_ack;
    logic          bus_wr_ni;
    logic [DW-1:0] bus_dataW;
    logic [DW-1:0] bus_dataR;
    logic [CW-1:0] fifo_count;

    btxn_t         exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            n_bus = 0;
    int            ack_cnt = 0;
    bit            srv_hold = 1'b0;
    bit            srv_vary = 1'b0;
    int            srv_delay = 0;
    logic [DW-1:0] srv_mem [16];
    logic [DW-1:0] ref_mem [16];
    int            lat;
    int            b0;
    int            a0;
    bit            bexp;

    always #5 clk = ~clk;

    client_wr_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .client_address(client_address), .client_rq(client_rq), .client_ack(client_ack),
        .client_wr_ni(client_wr_ni), .client_dataW(client_dataW), .client_dataR(client_dataR),
        .bus_address(bus_address), .bus_rq(bus_rq), .bus_ack(bus_ack), .bus_wr_ni(bus_wr_ni),
        .bus_dataW(bus_dataW), .bus_dataR(bus_dataR), .fifo_count(fifo_count)
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) if (client_ack) ack_cnt <= ack_cnt + 1;

    // Server: acks each bus request after a delay and checks it against the scoreboard.
    initial begin : server
        int    wait_cnt;
        int    dly;
        btxn_t e;
        wait_cnt  = 0;
        bus_ack   = 1'b0;
        bus_dataR = '0;
        for (int i = 0; i < 16; i++) srv_mem[i] = '0;
        forever begin
            @(posedge clk); #1;
            if (bus_ack) begin
                bus_ack = 1'b0;
                chk_val("bus_rq_gap", bus_rq, 1'b0);
            end else if (bus_rq && !srv_hold && !reset) begin
                dly = srv_vary ? (n_bus % 4) : srv_delay;
                if (wait_cnt >= dly) begin
                    wait_cnt = 0;
                    n_bus++;
                    if (exp_q.size() == 0) begin
                        chk_val("bus_unexp", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk_val("bus_wr_ni", bus_wr_ni, e.wr);
                        chk_val("bus_addr", bus_address, e.addr);
                        if (e.wr) chk_val("bus_dataW", bus_dataW, e.data);
                    end
                    if (bus_wr_ni) srv_mem[bus_address] = bus_dataW;
                    else           bus_dataR = srv_mem[bus_address];
                    bus_ack = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end else if (!bus_rq) begin
                wait_cnt = 0;
            end
        end
    end

    task automatic cli_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int l);
        btxn_t t;
        t.wr = 1'b1; t.addr = a; t.data = d;
        exp_q.push_back(t);
        ref_mem[a] = d;
        client_address = a; client_dataW = d; client_wr_ni = 1'b1; client_rq = 1'b1;
        l = 0;
        do begin @(posedge clk); #1; l++; end while (!client_ack && l < 200);
        chk_val("wr_ack_seen", client_ack, 1'b1);
        @(posedge clk); #1;
        client_rq = 1'b0;
        chk_val("wr_ack_pulse", client_ack, 1'b0);
    endtask

    task automatic cli_read(input logic [AW-1:0] a, input bit on_bus, output int l);
        btxn_t t;
        t.wr = 1'b0; t.addr = a; t.data = '0;
        if (on_bus) exp_q.push_back(t);
        client_address = a; client_wr_ni = 1'b0; client_rq = 1'b1;
        l = 0;
        do begin @(posedge clk); #1; l++; end while (!client_ack && l < 200);
        chk_val("rd_ack_seen", client_ack, 1'b1);
        chk_val("rd_data", client_dataR, ref_mem[a]);
        @(posedge clk); #1;
        client_rq = 1'b0;
        chk_val("rd_ack_pulse", client_ack, 1'b0);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(posedge clk); #1;
            ok = (fifo_count == '0) && !bus_rq && !bus_ack && (exp_q.size() == 0);
        end
        chk_val("drain_idle", ok, 1'b1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        reset = 1'b1; client_rq = 1'b0; client_wr_ni = 1'b0;
        client_address = '0; client_dataW = '0;
        repeat (3) @(posedge clk); #1;
        chk_val("rst_client_ack", client_ack, 1'b0);
        chk_val("rst_client_dataR", client_dataR, 8'h00);
        chk_val("rst_bus_rq", bus_rq, 1'b0);
        chk_val("rst_bus_wr_ni", bus_wr_ni, 1'b0);
        chk_val("rst_bus_address", bus_address, 4'h0);
        chk_val("rst_bus_dataW", bus_dataW, 8'h00);
        chk_val("rst_fifo_count", fifo_count, 3'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Posted write with an immediate server ack.
        srv_delay = 0;
        fork
            cli_write(4'd2, 8'h5A, lat);
            begin
                @(posedge clk); #1;
                chk_val("pw_cnt1", fifo_count, 3'd1);
                @(posedge clk); #1;
                chk_val("pw_bus_rq", bus_rq, 1'b1);
                chk_val("pw_bus_addr", bus_address, 4'd2);
                chk_val("pw_bus_wr", bus_wr_ni, 1'b1);
                chk_val("pw_bus_data", bus_dataW, 8'h5A);
                @(posedge clk); #1;
                chk_val("pw_cnt0", fifo_count, 3'd0);
            end
        join
        chk_val("pw_latency", lat, 2);
        wait_idle();

        // Full FIFO: fifth write waits for the first pop.
        srv_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cli_write(AW'(i), DW'(8'h30 + i), lat);
            chk_val("full_wr_lat", lat, 2);
        end
        chk_val("full_cnt4", fifo_count, 3'd4);
        a0 = ack_cnt;
        fork
            cli_write(4'd4, 8'h34, lat);
            begin
                repeat (6) @(posedge clk); #1;
                chk_val("full_no_ack", ack_cnt - a0, 0);
                chk_val("full_still4", fifo_count, 3'd4);
                srv_hold = 1'b0;
            end
        join
        chk_val("full_late_ack", lat > 6, 1'b1);
        wait_idle();

        // Ordering: read observes the earlier buffered write.
        cli_write(4'd3, 8'h11, lat);
        cli_read(4'd3, 1'b1, lat);
        wait_idle();

        // Wrap-around with varying server delay.
        b0 = n_bus;
        srv_vary = 1'b1;
        for (int i = 0; i < 10; i++) cli_write(AW'(i), DW'(8'hA0 + i), lat);
        wait_idle();
        srv_vary = 1'b0;
        chk_val("wrap_bus_cnt", n_bus - b0, 10);

        // Read of an address with two buffered writes.
        srv_hold = 1'b1;
        cli_write(4'd7, 8'h22, lat);
        cli_write(4'd7, 8'h33, lat);
        chk_val("fwd_cnt2", fifo_count, 3'd2);
`ifdef READ_FORWARD_EN
        bexp = 1'b0;
`else
        bexp = 1'b1;
`endif
        fork
            cli_read(4'd7, bexp, lat);
            begin
                repeat (8) @(posedge clk); #1;
                srv_hold = 1'b0;
            end
        join
`ifdef READ_FORWARD_EN
        chk_val("fwd_latency", lat, 2);
`else
        chk_val("rd_waits_drain", lat > 8, 1'b1);
`endif
        wait_idle();

        // Reset mid-stream drops buffered writes.
        srv_hold = 1'b1;
        cli_write(4'd12, 8'hC1, lat);
        cli_write(4'd13, 8'hC2, lat);
        cli_write(4'd14, 8'hC3, lat);
        chk_val("mid_cnt3", fifo_count, 3'd3);
        b0 = n_bus;
        reset = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk_val("mid_rst_cnt", fifo_count, 3'd0);
        chk_val("mid_rst_bus_rq", bus_rq, 1'b0);
        chk_val("mid_rst_ack", client_ack, 1'b0);
        reset = 1'b0;
        exp_q.delete();
        srv_hold = 1'b0;
        repeat (10) @(posedge clk); #1;
        chk_val("post_rst_bus_rq", bus_rq, 1'b0);
        chk_val("post_rst_no_bus", n_bus - b0, 0);
        chk_val("post_rst_cnt", fifo_count, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
